ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, which sets the operand and result width.
REQ-002 The module SHALL have the following ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  aborts the current operation (same signal as the ID/EX flush).
- start  in  1  ID/EX holds a valid RV64M instruction (opcode OP/OP-32 with func7=0000001).
- func3  in  3  RV64M operation select.
- is_word  in  1  OP-32 variant.
- op_a  in  DATA_WIDTH  rs1 value after forwarding.
- op_b  in  DATA_WIDTH  rs2 value after forwarding.
- stall  out  1  holds PC, IF/ID and ID/EX.
- done  out  1  result valid this cycle.
- result  out  DATA_WIDTH  final result.

Function
REQ-003 The unit SHALL implement the states IDLE, MUL, DIV, FIX and DONE.
REQ-004 In IDLE with start=1, the unit SHALL capture the operands, func3 and is_word, then go to MUL when func3[2]=0 and to DIV when func3[2]=1.
REQ-005 In IDLE with start=0, the unit SHALL stay in IDLE.
REQ-006 MUL SHALL last exactly one cycle, register the product, then go to DONE.
- Operations: MUL = low half; MULH = signed×signed high; MULHSU = signed×unsigned high; MULHU = unsigned×unsigned high.
REQ-007 DIV SHALL perform one restoring radix-2 iteration per cycle on operand magnitudes, for N cycles (N=64, or 32 when is_word=1), then go to FIX.
REQ-008 FIX SHALL last one cycle, apply sign correction, then go to DONE.
- Quotient is negated when the operand signs differ (signed ops).
- Remainder takes the dividend's sign.
REQ-009 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
- start is ignored in DONE, because ID/EX still holds the same instruction.
REQ-010 stall SHALL be combinational.
- stall = (state∈{MUL,DIV,FIX}) | (state==IDLE & start).
- stall SHALL be 0 in DONE so that ID/EX advances.
REQ-011 Latency from the start cycle to the DONE cycle SHALL be 2 cycles for multiply and N+2 cycles for divide.
REQ-012 result SHALL be registered, and equal 0 whenever done=0.
REQ-013 For is_word=1:
- Operate on op_a[31:0] and op_b[31:0], sign- or zero-extended per the op.
- Sign-extend bit 31 of the 32-bit result to DATA_WIDTH.
- func3 001–011 behave as MULW.
REQ-014 Divide by zero SHALL give quotient all-ones and remainder = dividend (32-bit value sign-extended for W ops).
REQ-015 Signed overflow (most-negative ÷ -1) SHALL give quotient = dividend and remainder 0.
REQ-016 flush=1 SHALL, in any state, move the unit to IDLE on the next edge with done=0 and no result produced.
- flush overrides start in the same cycle.

Reset
REQ-017 While reset=1, asynchronously: state=IDLE, done=0, result=0, internal quotient/remainder/counter=0.
- stall SHALL then follow start per REQ-010.
REQ-018 Reset asserted mid-operation SHALL discard the operation; after release the unit SHALL accept a new start in IDLE.

Configuration
REQ-019 With macro MULDIV_EARLY_OUT_EN defined, a divide whose divisor is 0 or which overflows SHALL go IDLE→DONE directly, with latency 1, carrying the REQ-014/015 results.
REQ-020 Without MULDIV_EARLY_OUT_EN, such divides SHALL take the full N+2 cycles with identical results.

Verification
REQ-021 Multiply: start, func3=000, op_a=7, op_b=-3 → stall high for cycles 0–1, done in cycle 2, result=0xFFFFFFFFFFFFFFEB.
REQ-022 MULHU: op_a=op_b=0xFFFFFFFFFFFFFFFF → result=0xFFFFFFFFFFFFFFFE.
REQ-023 DIVW: op_a=0x00000000FFFFFFF9 (-7), op_b=2 → done at cycle 34, result=0xFFFFFFFFFFFFFFFD; REMW with the same operands → 0xFFFFFFFFFFFFFFFF.
REQ-024 DIVU by zero, op_a=5 → quotient 0xFFFFFFFFFFFFFFFF, at cycle 66 without MULDIV_EARLY_OUT_EN and cycle 1 with it; REMU by zero → 5.
REQ-025 DIV with op_a=0x8000000000000000, op_b=-1 → result 0x8000000000000000; REM → 0.
REQ-026 Flush asserted at DIV cycle 10, then reset asserted mid-DIV on a second run → both return to IDLE with done never asserted; a following MUL 6×7 → 42 at cycle 2.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Handshake/data bundle between the ID/EX stage and the RV64M multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  flush;
    logic                  start;
    logic [2:0]            func3;
    logic                  is_word;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  stall;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output flush, start, func3, is_word, op_a, op_b,
        input  stall, done, result
    );

    modport slave (
        input  flush, start, func3, is_word, op_a, op_b,
        output stall, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV64M execute unit: single-cycle multiply, radix-2 restoring divide with a
// sign-fix cycle, and a one-cycle DONE slot that releases the pipeline stall.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip the iterative divide and finish straight from IDLE.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    ex_muldiv_unit_if.slave    bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]    f3_q, f3_d;
    logic          word_q, word_d;
    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  result_q, result_d;

    function automatic logic [W-1:0] sext32(input logic [31:0] v);
        return {{(W-32){v[31]}}, v};
    endfunction

    // Divide operands: W ops use the low word, sign- or zero-extended.
    function automatic logic [W-1:0] ext_op(input logic [W-1:0] v, input logic word,
                                            input logic sgn);
        return word ? {{(W-32){sgn & v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic is_ovf(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                    input logic word, input logic sgn);
        logic [W-1:0] min_v;
        min_v = word ? {{(W-31){1'b1}}, {31{1'b0}}} : {1'b1, {(W-1){1'b0}}};
        return sgn && (dvd == min_v) && (dvs == {W{1'b1}});
    endfunction

    // Final divide result from unsigned quotient/remainder magnitudes; the
    // zero-divisor and overflow cases override whatever the iteration made.
    function automatic logic [W-1:0] div_result(input logic [W-1:0] qm, input logic [W-1:0] rm,
                                                input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                                input logic [2:0] f3, input logic word);
        logic sgn, na, nb;
        logic [W-1:0] q, r, res;
        sgn = ~f3[0];
        na  = sgn & dvd[W-1];
        nb  = sgn & dvs[W-1];
        q   = neg_if(qm, na ^ nb);
        r   = neg_if(rm, na);
        if (dvs == '0) begin
            q = {W{1'b1}};
            r = dvd;
        end else if (is_ovf(dvd, dvs, word, sgn)) begin
            q = dvd;
            r = '0;
        end
        res = f3[1] ? r : q;
        return word ? sext32(res[31:0]) : res;
    endfunction

    // Operand views of the incoming instruction (used when leaving IDLE).
    logic         in_sgn;
    logic [W-1:0] in_dvd, in_dvs;
    assign in_sgn = ~bus.func3[0];
    assign in_dvd = ext_op(bus.op_a, bus.is_word, in_sgn);
    assign in_dvs = ext_op(bus.op_b, bus.is_word, in_sgn);

    // Operand views of the captured instruction (used in FIX).
    logic         cap_sgn;
    logic [W-1:0] cap_dvd, cap_dvs;
    assign cap_sgn = ~f3_q[0];
    assign cap_dvd = ext_op(a_q, word_q, cap_sgn);
    assign cap_dvs = ext_op(b_q, word_q, cap_sgn);

    // Multiplier: extending both operands to 2W bits and keeping a 2W-bit
    // product gives exact high halves for all three signedness mixes.
    logic           mul_sa, mul_sb;
    logic [2*W-1:0] ma, mb, prod;
    logic [W-1:0]   mul_res;
    assign mul_sa  = (f3_q == 3'b001) || (f3_q == 3'b010);
    assign mul_sb  = (f3_q == 3'b001);
    assign ma      = {{W{mul_sa & a_q[W-1]}}, a_q};
    assign mb      = {{W{mul_sb & b_q[W-1]}}, b_q};
    assign prod    = ma * mb;
    assign mul_res = word_q ? sext32(prod[31:0])
                   : (f3_q == 3'b000) ? prod[W-1:0] : prod[2*W-1:W];

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [W:0] shifted, trial;
    assign shifted = {rem_q, quo_q[W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // Next-state and datapath: hold by default, flush wins over everything.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        f3_d     = f3_q;
        word_d   = word_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d    = bus.op_a;
                    b_d    = bus.op_b;
                    f3_d   = bus.func3;
                    word_d = bus.is_word;
                    if (!bus.func3[2]) begin
                        state_d = S_MUL;
                    end else begin
                        rem_d   = '0;
                        quo_d   = neg_if(in_dvd, in_sgn & in_dvd[W-1]);
                        if (bus.is_word) quo_d = quo_d << 32;
                        dvs_d   = neg_if(in_dvs, in_sgn & in_dvs[W-1]);
                        cnt_d   = bus.is_word ? CW'(31) : CW'(W - 1);
                        state_d = S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
                        if ((in_dvs == '0) || is_ovf(in_dvd, in_dvs, bus.is_word, in_sgn)) begin
                            state_d  = S_DONE;
                            result_d = div_result('0, '0, in_dvd, in_dvs, bus.func3, bus.is_word);
                        end
`else
                        // Zero divisor and overflow run the full iteration;
                        // FIX substitutes their architectural results.
`endif
                    end
                end
            end
            S_MUL: begin
                result_d = mul_res;
                state_d  = S_DONE;
            end
            S_DIV: begin
                rem_d = trial[W] ? shifted[W-1:0] : trial[W-1:0];
                quo_d = {quo_q[W-2:0], ~trial[W]};
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_FIX: begin
                result_d = div_result(quo_q, rem_q, cap_dvd, cap_dvs, f3_q, word_q);
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            word_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f3_q     <= f3_d;
            word_q   <= word_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.stall  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX) ||
                        ((state_q == S_IDLE) && bus.start);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: the driver queues hand-computed
// results and latencies, a monitor checks every DONE cycle against them.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ex_muldiv_unit_if #(.DATA_WIDTH(64)) bus ();
    ex_muldiv_unit #(.DATA_WIDTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [63:0] res;
        int          scyc;
        int          lat;
        int          id;
    } exp_t;
    exp_t sb_q[$];

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 1;
`else
    localparam int LAT_SPECIAL = 66;
`endif

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every DONE must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.done) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_done got result=%h cyc=%0d", bus.result, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        if (bus.result !== e.res) begin
                            failures++;
                            $display("FAIL op%0d_result got=%h want=%h", e.id, bus.result, e.res);
                        end
                        checks++;
                        if (cyc - e.scyc != e.lat) begin
                            failures++;
                            $display("FAIL op%0d_latency got=%0d want=%0d", e.id, cyc - e.scyc, e.lat);
                        end
                    end
                end else begin
                    checks++;
                    if (bus.result !== 64'd0) begin
                        failures++;
                        $display("FAIL result_zero_when_idle got=%h want=0", bus.result);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic run_op(input int id, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] expv, input int lat);
        exp_t e;
        int   n;
        logic stall_ok, seen;
        @(negedge clk);
        #1;
        bus.start = 1'b1; bus.func3 = f3; bus.is_word = w; bus.op_a = a; bus.op_b = b;
        e.res = expv; e.scyc = cyc; e.lat = lat; e.id = id;
        sb_q.push_back(e);
        #1;
        stall_ok = bus.stall;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else begin
                if (!bus.stall) stall_ok = 1'b0;
                n++;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL op%0d_timeout no done within 200 cycles", id);
            #1;
            bus.start = 1'b0; bus.flush = 1'b1;
            @(negedge clk);
            #1;
            bus.flush = 1'b0;
            sb_q.delete();
        end else begin
            check($sformatf("op%0d_stall_in_done", id), {63'd0, bus.stall}, 64'd0);
            check($sformatf("op%0d_stall_while_busy", id), {63'd0, stall_ok}, 64'd1);
            #1;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        bus.flush = 1'b0; bus.start = 1'b0; bus.func3 = 3'b000; bus.is_word = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        #3;
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_result", bus.result, 64'd0);
        check("reset_stall_idle", {63'd0, bus.stall}, 64'd0);
        bus.start = 1'b1;
        #1;
        check("reset_stall_follows_start", {63'd0, bus.stall}, 64'd1);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Multiplies
        run_op(1,  3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFFFFFFFFFFFFEB, 2);
        run_op(2,  3'b011, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 2);
        run_op(3,  3'b001, 1'b0, '1, '1, 64'h0, 2);
        run_op(4,  3'b010, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFF, 2);
        run_op(5,  3'b000, 1'b1, 64'hFFFFFFFF7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 2);
        run_op(6,  3'b011, 1'b1, 64'h0000000040000000, 64'd2, 64'hFFFFFFFF80000000, 2);
        // Word divides
        run_op(7,  3'b100, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 34);
        run_op(8,  3'b110, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 34);
        run_op(9,  3'b101, 1'b1, 64'hFFFFFFFFFFFFFFFE, 64'd2, 64'h000000007FFFFFFF, 34);
        // Full-width divides
        run_op(10, 3'b100, 1'b0, 64'd100, -64'sd7, 64'hFFFFFFFFFFFFFFF2, 66);
        run_op(11, 3'b110, 1'b0, -64'sd100, 64'd7, 64'hFFFFFFFFFFFFFFFE, 66);
        run_op(12, 3'b101, 1'b0, '1, 64'h10, 64'h0FFFFFFFFFFFFFFF, 66);
        // Divide by zero and signed overflow
        run_op(13, 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, LAT_SPECIAL);
        run_op(14, 3'b111, 1'b0, 64'd5, 64'd0, 64'd5, LAT_SPECIAL);
        run_op(15, 3'b100, 1'b0, 64'h8000000000000000, '1, 64'h8000000000000000, LAT_SPECIAL);
        run_op(16, 3'b110, 1'b0, 64'h8000000000000000, '1, 64'd0, LAT_SPECIAL);

        // Flush at DIV cycle 10: no DONE may follow.
        @(negedge clk); #1;
        bus.start = 1'b1; bus.func3 = 3'b100; bus.is_word = 1'b0; bus.op_a = 64'd100; bus.op_b = 64'd7;
        repeat (10) @(negedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b1;
        @(negedge clk); #1;
        bus.flush = 1'b0;
        #1;
        check("flush_back_to_idle_stall", {63'd0, bus.stall}, 64'd0);
        check("flush_no_done", {63'd0, bus.done}, 64'd0);
        repeat (70) @(negedge clk);

        // Flush overrides start in IDLE.
        #1;
        bus.start = 1'b1; bus.func3 = 3'b000; bus.flush = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("flush_over_start_stall", {63'd0, bus.stall}, 64'd0);
        repeat (4) @(negedge clk);

        // Reset mid-divide.
        #1;
        bus.start = 1'b1; bus.func3 = 3'b100; bus.op_a = 64'd100; bus.op_b = 64'd7;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset_done", {63'd0, bus.done}, 64'd0);
        check("midreset_result", bus.result, 64'd0);
        check("midreset_stall_follows_start", {63'd0, bus.stall}, 64'd1);
        bus.start = 1'b0;
        #1;
        check("midreset_stall_idle", {63'd0, bus.stall}, 64'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (70) @(negedge clk);

        run_op(17, 3'b000, 1'b0, 64'd6, 64'd7, 64'd42, 2);

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained got=%0d pending want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
